debounce_bank: RTL
==================

# debounce_bank

Parametrised multi-channel button debouncer for the Basys3 designs. Each of `N_CH` asynchronous inputs is synchronised, filtered by a per-channel tick-based stability counter, and presented as a clean level. It also produces single-cycle press, release and hold/auto-repeat event pulses. It sits between the board pins (buttons, switches) and the RISC-V core's GPIO/control logic, replacing per-button single-channel debouncers.

## Interface
Parameters:
- `N_CH`, 5: number of independent channels; must be ≥1.
- `STABLE_COUNT`, 255: consecutive ticks a new level must persist before `btn_clean` adopts it; must be ≥1.
- `HOLD_COUNT`, 1000: ticks with `btn_clean`=1, counted after the rise, before the first `btn_hold` pulse; must be ≥1.
- `REPEAT_COUNT`, 250: ticks between subsequent `btn_hold` pulses while held; 0 disables auto-repeat.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tick`  in  1  sample-rate enable; counters advance only on cycles with `tick`=1; tie high for per-clock counting.
- `btn`  in  N_CH  raw asynchronous inputs.
- `btn_clean`  out  N_CH  debounced level.
- `btn_rise`  out  N_CH  1-cycle pulse when `btn_clean` goes 0→1.
- `btn_fall`  out  N_CH  1-cycle pulse when `btn_clean` goes 1→0.
- `btn_hold`  out  N_CH  1-cycle pulse at hold threshold and at each repeat interval.

## Operation
- Synchroniser: 2-flop chain per channel (`s1`, `s2`), runs every cycle regardless of `tick`. Only `s2` feeds the filter.
- Filter, per channel (all registers reset to 0):
  - If `s2` == `btn_clean`: `cnt` <= 0, whatever the state of `tick`.
  - Else if `tick`=1 and `cnt` == `STABLE_COUNT`-1: `btn_clean` <= `s2` and `cnt` <= 0. `btn_rise` or `btn_fall` (matching the new level) is 1 for that one following cycle.
  - Else if `tick`=1: `cnt` <= `cnt`+1.
  - Else: hold.
  - Any sample equal to the current clean level restarts the count, so a glitch shorter than `STABLE_COUNT` ticks never changes the output.
- Counter width is `$clog2(STABLE_COUNT+1)`, and the counter never wraps.
- Hold/repeat, per channel. State is `hcnt` plus a `rep` phase bit.
  - `btn_clean`=0, or the cycle of any clean update: `hcnt` <= 0 and `rep` <= 0.
  - `btn_clean`=1 and `tick`=1: compare `hcnt` with the limit, which is `HOLD_COUNT`-1 when `rep`=0 and `REPEAT_COUNT`-1 when `rep`=1.
    - On match: `btn_hold` pulses, `hcnt` <= 0, `rep` <= 1.
    - Otherwise: `hcnt` <= `hcnt`+1.
  - If `REPEAT_COUNT`=0, no pulses occur after the first. `hcnt` saturates and `rep` stays 1 until release.
  - Width of `hcnt` is `$clog2(max(HOLD_COUNT,REPEAT_COUNT)+1)`.
- Channels are fully independent, and simultaneous events on different channels are all reported in the same cycle.
- Reset mid-operation: every counter, synchroniser stage and output returns to 0 on the next edge, and no pulse is emitted on that edge. An input held high through reset produces a normal filtered press (`btn_rise` included) after release from reset.

## Timing
- Reset values: `btn_clean`, `btn_rise`, `btn_fall`, `btn_hold` all 0.
- All outputs are registered; there is no combinational path from `btn` or `tick`.
- Press latency with `tick`=1: for an input first sampled high at edge E, `btn_clean`=1 and `btn_rise`=1 after edge E+STABLE_COUNT+1. `btn_rise` drops after the next edge.
- With `tick` gated, latency is 2 cycles plus the time to accumulate `STABLE_COUNT` tick cycles of mismatch.
- Hold timing: with `btn_clean` rising at edge R and `tick`=1, the first `btn_hold` is high after edge R+HOLD_COUNT. Repeats follow every `REPEAT_COUNT` cycles after that.
- `btn_rise`/`btn_fall` never coincide with `btn_hold` on the same channel.

## Test plan
- Clean press and release: `STABLE_COUNT`=4, `tick`=1, ch0 rises at edge E. Required: `btn_clean[0]`=1 and `btn_rise[0]`=1 after edge E+5, `btn_rise` low again after E+6. Release mirrors this with `btn_fall`.
- Glitch rejection: `STABLE_COUNT`=4, ch1 pulses high for 3 cycles, low for 1, high for 3. Required: `btn_clean[1]` stays 0, with no rise or fall pulses.
- Bounce then settle: 10 random toggles shorter than 4 cycles, then steady high. Required: exactly one `btn_rise`, 5 cycles after the last edge.
- Hold and repeat: `HOLD_COUNT`=10, `REPEAT_COUNT`=3, press held for 20 cycles after rise edge R. Required: `btn_hold` pulses after R+10, R+13, R+16 and R+19, and none after release. With `REPEAT_COUNT`=0, only the pulse after R+10 occurs.
- Tick gating: `tick` high on 1 cycle in 4, `STABLE_COUNT`=4. Required: the clean change lands on the 4th mismatching tick cycle, and there is no change while `tick` is held 0.
- Reset and multi-channel: all 5 channels pressed together, `rst` pulsed mid-count on one edge. Required: all outputs 0 the next cycle. Each channel re-filters and all `btn_rise` bits assert in the same cycle, 5 cycles after the first post-reset sample.

Source files
------------

// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel button debouncer.
// Each channel passes through a 2-flop synchroniser, then a tick-driven
// stability counter that only adopts a new level after STABLE_COUNT
// consecutive mismatching ticks. The clean level also drives a hold /
// auto-repeat timer that emits single-cycle btn_hold pulses.
// All outputs are registered; nothing combinational reaches the ports.
module debounce_bank #(
  parameter int N_CH         = 5,
  parameter int STABLE_COUNT = 255,
  parameter int HOLD_COUNT   = 1000,
  parameter int REPEAT_COUNT = 250
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] btn_clean,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_hold
);

  // Stability counter counts 0..STABLE_COUNT-1 and never wraps.
  localparam int CW   = $clog2(STABLE_COUNT + 1);
  // Hold counter must reach the larger of the two limits.
  localparam int HMAX = (HOLD_COUNT > REPEAT_COUNT) ? HOLD_COUNT : REPEAT_COUNT;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_COUNT - 1);
  // REPEAT_COUNT=0 disables auto-repeat; the limit is then never used.
  localparam logic [HW-1:0] REP_LAST  = (REPEAT_COUNT > 0) ? HW'(REPEAT_COUNT - 1) : '0;
  localparam bit            REP_EN    = (REPEAT_COUNT > 0);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          clean_q;
    logic          rise_q;
    logic          fall_q;
    logic [HW-1:0] hcnt;
    logic          rep;
    logic          hold_q;
    logic          mismatch;
    logic          update;

    // Synchronised sample differs from the current clean level.
    assign mismatch = (s2 != clean_q);
    // This edge adopts the new level: last required tick of a mismatch run.
    assign update   = mismatch && tick && (cnt == CNT_LAST);

    // Two-flop synchroniser, free running (independent of tick).
    always_ff @(posedge clk) begin
      if (rst) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= btn[g];
        s2 <= s1;
      end
    end

    // Stability filter: any matching sample restarts the count; clean level
    // and the rise/fall pulse update together on the final tick.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= update &  s2;
        fall_q <= update & ~s2;
        if (!mismatch) begin
          cnt <= '0;
        end else if (update) begin
          clean_q <= s2;
          cnt     <= '0;
        end else if (tick) begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    // Hold / auto-repeat timer: first pulse after HOLD_COUNT ticks of a
    // steady high level, then every REPEAT_COUNT ticks (rep selects limit).
    // Clearing on an update keeps hold pulses off the rise/fall cycles.
    always_ff @(posedge clk) begin
      hold_q <= 1'b0;
      if (rst || !clean_q || update) begin
        hcnt <= '0;
        rep  <= 1'b0;
      end else if (tick) begin
        if (rep && !REP_EN) begin
          if (hcnt != '1) hcnt <= hcnt + 1'b1;
        end else if (hcnt == (rep ? REP_LAST : HOLD_LAST)) begin
          hold_q <= 1'b1;
          hcnt   <= '0;
          rep    <= 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end

    assign btn_clean[g] = clean_q;
    assign btn_rise[g]  = rise_q;
    assign btn_fall[g]  = fall_q;
    assign btn_hold[g]  = hold_q;
  end

endmodule
